// File: rtl/reg_bank_nch.sv
// Multi-channel register bank with optional shadow/commit double buffering.
// CHANGED flags any edge that altered DOUT; RST clears everything without a clock.
module reg_bank_nch #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int MODE     = 0,
    localparam int SW      = $clog2(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      WE,
    input  logic [SW-1:0]             WSEL,
    input  logic [WIDTH-1:0]          WDATA,
    input  logic                      CLR,
    input  logic                      COMMIT,
    output logic [CHANNELS*WIDTH-1:0] DOUT,
    output logic [CHANNELS-1:0]       VALID,
    output logic                      CHANGED,
    output logic                      PENDING
);

    logic [CHANNELS*WIDTH-1:0] dout_q, dout_d;
    logic [CHANNELS*WIDTH-1:0] shadow_q, shadow_d;
    logic [CHANNELS-1:0]       valid_q, valid_d;
    logic [CHANNELS-1:0]       svalid_q, svalid_d;
    logic                      pending_q, pending_d;
    logic                      changed_q;
    logic                      wr_ok;

    assign wr_ok = WE && ({1'b0, WSEL} < (SW+1)'(CHANNELS));

    always_comb begin
        dout_d    = dout_q;
        shadow_d  = shadow_q;
        valid_d   = valid_q;
        svalid_d  = svalid_q;
        pending_d = pending_q;
        if (CLR) begin
            dout_d    = '0;
            shadow_d  = '0;
            valid_d   = '0;
            svalid_d  = '0;
            pending_d = 1'b0;
        end else if (MODE == 0) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (wr_ok && WSEL == SW'(k)) begin
                    dout_d[k*WIDTH +: WIDTH] = WDATA;
                    valid_d[k]               = 1'b1;
                end
            end
            pending_d = 1'b0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (wr_ok && WSEL == SW'(k)) begin
                    shadow_d[k*WIDTH +: WIDTH] = WDATA;
                    svalid_d[k]                = 1'b1;
                end
            end
            // A same-cycle write is folded into the commit it rides with.
            if (COMMIT && (pending_q || wr_ok)) begin
                dout_d    = shadow_d;
                valid_d   = valid_q | svalid_d;
                pending_d = 1'b0;
            end else if (wr_ok) begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            dout_q    <= '0;
            shadow_q  <= '0;
            valid_q   <= '0;
            svalid_q  <= '0;
            pending_q <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            dout_q    <= dout_d;
            shadow_q  <= shadow_d;
            valid_q   <= valid_d;
            svalid_q  <= svalid_d;
            pending_q <= pending_d;
            changed_q <= (dout_d != dout_q);
        end
    end

    assign DOUT    = dout_q;
    assign VALID   = valid_q;
    assign CHANGED = changed_q;
    assign PENDING = pending_q;

endmodule

// File: tb/tb_reg_bank_nch.sv
// Directed bench: direct and shadow banks share one vector table,
// plus hand sequences for reset and the 3-channel out-of-range case.
module tb_reg_bank_nch;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        we = 1'b0, clr = 1'b0, commit = 1'b0, we3 = 1'b0;
    logic        wsel = 1'b0;
    logic [1:0]  wsel3 = 2'd0;
    logic [3:0]  wdata = 4'd0;

    logic [7:0]  d0, d1;
    logic [1:0]  v0, v1;
    logic        c0, c1, p0, p1;
    logic [11:0] d3;
    logic [2:0]  v3;
    logic        c3, p3;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    reg_bank_nch #(.WIDTH(4), .CHANNELS(2), .MODE(0)) u0 (
        .CLK(CLK), .RST(RST), .WE(we), .WSEL(wsel), .WDATA(wdata),
        .CLR(clr), .COMMIT(commit), .DOUT(d0), .VALID(v0),
        .CHANGED(c0), .PENDING(p0));

    reg_bank_nch #(.WIDTH(4), .CHANNELS(2), .MODE(1)) u1 (
        .CLK(CLK), .RST(RST), .WE(we), .WSEL(wsel), .WDATA(wdata),
        .CLR(clr), .COMMIT(commit), .DOUT(d1), .VALID(v1),
        .CHANGED(c1), .PENDING(p1));

    reg_bank_nch #(.WIDTH(4), .CHANNELS(3), .MODE(1)) u3 (
        .CLK(CLK), .RST(RST), .WE(we3), .WSEL(wsel3), .WDATA(wdata),
        .CLR(clr), .COMMIT(commit), .DOUT(d3), .VALID(v3),
        .CHANGED(c3), .PENDING(p3));

    typedef struct {
        logic       we;
        logic       wsel;
        logic [3:0] wdata;
        logic       clr;
        logic       commit;
        logic [7:0] d0;
        logic [1:0] v0;
        logic       c0;
        logic [7:0] d1;
        logic [1:0] v1;
        logic       p1;
        logic       c1;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        //            we ws wd  clr cm  d0     v0    c0  d1     v1    p1  c1
        tbl[0]  = '{1, 0, 4'h5, 0, 0, 8'h05, 2'b01, 1, 8'h00, 2'b00, 1, 0};
        tbl[1]  = '{1, 1, 4'hA, 0, 0, 8'hA5, 2'b11, 1, 8'h00, 2'b00, 1, 0};
        tbl[2]  = '{0, 0, 4'h0, 0, 0, 8'hA5, 2'b11, 0, 8'h00, 2'b00, 1, 0};
        tbl[3]  = '{0, 0, 4'h0, 0, 1, 8'hA5, 2'b11, 0, 8'hA5, 2'b11, 0, 1};
        tbl[4]  = '{0, 0, 4'h0, 0, 1, 8'hA5, 2'b11, 0, 8'hA5, 2'b11, 0, 0};
        tbl[5]  = '{1, 0, 4'h3, 0, 0, 8'hA3, 2'b11, 1, 8'hA5, 2'b11, 1, 0};
        tbl[6]  = '{1, 1, 4'h7, 0, 0, 8'h73, 2'b11, 1, 8'hA5, 2'b11, 1, 0};
        tbl[7]  = '{0, 0, 4'h0, 0, 1, 8'h73, 2'b11, 0, 8'h73, 2'b11, 0, 1};
        tbl[8]  = '{1, 0, 4'h9, 0, 1, 8'h79, 2'b11, 1, 8'h79, 2'b11, 0, 1};
        tbl[9]  = '{1, 0, 4'h9, 0, 0, 8'h79, 2'b11, 0, 8'h79, 2'b11, 1, 0};
        tbl[10] = '{0, 0, 4'h0, 0, 1, 8'h79, 2'b11, 0, 8'h79, 2'b11, 0, 0};
        tbl[11] = '{1, 1, 4'hF, 1, 1, 8'h00, 2'b00, 1, 8'h00, 2'b00, 0, 1};
        tbl[12] = '{0, 0, 4'h0, 0, 0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 0, 0};
        tbl[13] = '{1, 1, 4'h2, 0, 0, 8'h20, 2'b10, 1, 8'h00, 2'b00, 1, 0};
        tbl[14] = '{1, 1, 4'h4, 0, 0, 8'h40, 2'b10, 1, 8'h00, 2'b00, 1, 0};
        tbl[15] = '{0, 0, 4'h0, 0, 1, 8'h40, 2'b10, 0, 8'h40, 2'b10, 0, 1};
        tbl[16] = '{0, 0, 4'h0, 1, 0, 8'h00, 2'b00, 1, 8'h00, 2'b00, 0, 1};
        tbl[17] = '{1, 0, 4'h3, 0, 0, 8'h03, 2'b01, 1, 8'h00, 2'b00, 1, 0};
        tbl[18] = '{1, 1, 4'h7, 0, 1, 8'h73, 2'b11, 1, 8'h73, 2'b11, 0, 1};
        tbl[19] = '{1, 1, 4'hF, 1, 0, 8'h00, 2'b00, 1, 8'h00, 2'b00, 0, 1};

        #12;
        chk("rst.d0", 32'(d0), 32'h0);
        chk("rst.d1", 32'(d1), 32'h0);
        chk("rst.flags", 32'({v0, v1, c0, c1, p0, p1}), 32'h0);
        #5 RST = 1'b1;
        step();
        chk("rel.chg", 32'({c0, c1, c3}), 32'h0);

        for (int i = 0; i < 20; i++) begin
            we     = tbl[i].we;
            wsel   = tbl[i].wsel;
            wdata  = tbl[i].wdata;
            clr    = tbl[i].clr;
            commit = tbl[i].commit;
            step();
            chk($sformatf("v%0d.d0", i), 32'(d0), 32'(tbl[i].d0));
            chk($sformatf("v%0d.v0", i), 32'(v0), 32'(tbl[i].v0));
            chk($sformatf("v%0d.c0", i), 32'(c0), 32'(tbl[i].c0));
            chk($sformatf("v%0d.p0", i), 32'(p0), 32'h0);
            chk($sformatf("v%0d.d1", i), 32'(d1), 32'(tbl[i].d1));
            chk($sformatf("v%0d.v1", i), 32'(v1), 32'(tbl[i].v1));
            chk($sformatf("v%0d.p1", i), 32'(p1), 32'(tbl[i].p1));
            chk($sformatf("v%0d.c1", i), 32'(c1), 32'(tbl[i].c1));
        end
        we = 1'b0; clr = 1'b0; commit = 1'b0;

        // three channels: out-of-range index and identical rewrite
        we3 = 1'b1; wsel3 = 2'd0; wdata = 4'h5; commit = 1'b1;
        step();
        chk("c3.wr.d", 32'(d3), 32'h005);
        chk("c3.wr.v", 32'(v3), 32'h1);
        chk("c3.wr.c", 32'(c3), 32'h1);
        wsel3 = 2'd3; wdata = 4'hF; commit = 1'b0;
        step();
        chk("c3.oor.d", 32'(d3), 32'h005);
        chk("c3.oor.vp", 32'({v3, p3}), 32'({3'b001, 1'b0}));
        chk("c3.oor.c", 32'(c3), 32'h0);
        commit = 1'b1;
        step();
        chk("c3.oorc.d", 32'(d3), 32'h005);
        chk("c3.oorc.p", 32'(p3), 32'h0);
        wsel3 = 2'd0; wdata = 4'h5;
        step();
        chk("c3.same.d", 32'(d3), 32'h005);
        chk("c3.same.c", 32'(c3), 32'h0);
        wsel3 = 2'd2; wdata = 4'hC;
        step();
        chk("c3.ch2.d", 32'(d3), 32'hC05);
        chk("c3.ch2.v", 32'(v3), 32'h5);
        chk("c3.ch2.c", 32'(c3), 32'h1);
        we3 = 1'b0; commit = 1'b0;
        step();
        chk("c3.idle.c", 32'(c3), 32'h0);

        // reset between edges discards the uncommitted shadow
        we = 1'b1; wsel = 1'b0; wdata = 4'h6;
        step();
        we = 1'b0;
        chk("ar.pend", 32'(p1), 32'h1);
        chk("ar.d0", 32'(d0), 32'h06);
        #2 RST = 1'b0;
        #1;
        chk("ar.d1", 32'(d1), 32'h0);
        chk("ar.d0z", 32'(d0), 32'h0);
        chk("ar.d3", 32'(d3), 32'h0);
        chk("ar.flags", 32'({v0, v1, v3, p1, p3, c0, c1, c3}), 32'h0);
        #1 RST = 1'b1;
        commit = 1'b1;
        step();
        commit = 1'b0;
        chk("ar.cm.d1", 32'(d1), 32'h0);
        chk("ar.cm.p1", 32'(p1), 32'h0);
        chk("ar.cm.c", 32'({c0, c1}), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
